// File: rtl/ft_pkg.sv
// ft_pkg -- definitions shared by the FT245-style synchronous FIFO transmitter.
//   FT_BYTE_W     : width of one byte on the ft_data bus
//   ft_tx_state_t : transmit bus-ownership state machine encoding
package ft_pkg;

  localparam int unsigned FT_BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    TURN,
    WRITE,
    RELEASE
  } ft_tx_state_t;

endpackage

// File: rtl/ft_tx_fifo.sv
// ft_tx_fifo -- synchronous single-clock FIFO with occupancy output.
//   clk_i    : clock
//   rst_i    : synchronous active-high flush
//   push_i   : write wdata_i (ignored when full)
//   wdata_i  : entry to write
//   pop_i    : discard head entry (ignored when empty)
//   rdata_o  : current head entry (valid when level_o != 0)
//   level_o  : number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module ft_tx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [LW-1:0] ONE_LVL  = LW'(1);
  localparam logic [AW-1:0] ONE_PTR  = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign do_push = push_i && (cnt_q != FULL_LVL);
  assign do_pop  = pop_i  && (cnt_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + ONE_PTR;
    if (do_pop)  rd_ptr_d = rd_ptr_q + ONE_PTR;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + ONE_LVL;
      2'b01:   cnt_d = cnt_q - ONE_LVL;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset; only the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push && !rst_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = cnt_q;

endmodule

// File: rtl/ft_tx.sv
// ft_tx -- transmit side of an FT245-style synchronous FIFO bridge.
// Bytes from the fabric are buffered, then written to the FT chip while it
// reports space (TXE# low), sharing the ft_data bus with a reader block.
//   ft_clk      : 60 MHz FT clock, sole clock
//   rst         : synchronous active-high reset
//   tx_data/tx_valid/tx_last/tx_ready : fabric byte stream (valid/ready)
//   rx_busy     : reader owns ft_data; start of a transfer waits for it
//   tx_busy     : this block owns ft_data; reader holds off
//   ft_txen     : FT TXE#, active low
//   ft_wrn      : FT WR#, active low, registered
//   ft_data_out : byte driven onto ft_data
//   ft_data_oe  : tristate enable for ft_data at the top level
//   ft_siwu     : FT SIWU#, active low send-immediate
//   level       : FIFO occupancy
// Build option: define FT_TX_SIWU_EN to store tx_last and pulse SIWU# once
// after each transfer burst that carried a message-ending byte; otherwise
// SIWU# is tied inactive and tx_last is dropped.
module ft_tx
  import ft_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                   ft_clk,
  input  logic                   rst,
  input  logic [FT_BYTE_W-1:0]   tx_data,
  input  logic                   tx_valid,
  input  logic                   tx_last,
  output logic                   tx_ready,
  input  logic                   rx_busy,
  output logic                   tx_busy,
  input  logic                   ft_txen,
  output logic                   ft_wrn,
  output logic [FT_BYTE_W-1:0]   ft_data_out,
  output logic                   ft_data_oe,
  output logic                   ft_siwu,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [LW-1:0] ONE_LVL  = LW'(1);

`ifdef FT_TX_SIWU_EN
  localparam int unsigned FW = FT_BYTE_W + 1;
`else
  localparam int unsigned FW = FT_BYTE_W;
`endif

  ft_tx_state_t  state_q, state_d;
  logic          wrn_q, wrn_d;
  logic          push, pop;
  logic [FW-1:0] fifo_wdata, fifo_head;

`ifdef FT_TX_SIWU_EN
  assign fifo_wdata = {tx_last, tx_data};
`else
  logic unused_tx_last;
  assign unused_tx_last = tx_last;
  assign fifo_wdata     = tx_data;
`endif

  assign tx_ready = !rst && (level < FULL_LVL);
  assign push     = tx_valid && tx_ready;
  // A byte counts as delivered only when WR# and TXE# are both low at the edge.
  assign pop      = (state_q == WRITE) && !wrn_q && !ft_txen && (level != '0);

  ft_tx_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (ft_clk),
    .rst_i   (rst),
    .push_i  (push),
    .wdata_i (fifo_wdata),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .level_o (level)
  );

  always_comb begin
    state_d = state_q;
    wrn_d   = 1'b1;
    case (state_q)
      IDLE: begin
        if ((level != '0) && !rx_busy && !ft_txen) state_d = TURN;
      end
      TURN: begin
        // Nothing pops outside WRITE, so the head seen in IDLE is still there.
        state_d = WRITE;
        wrn_d   = 1'b0;
      end
      WRITE: begin
        if (wrn_q) begin
          if (level == '0) state_d = RELEASE;
          else             wrn_d   = 1'b0;
        end else if (ft_txen) begin
          // Chip refused the byte: keep it queued and give up the bus.
          state_d = RELEASE;
        end else if ((level == ONE_LVL) && !push) begin
          state_d = RELEASE;
        end else begin
          wrn_d = 1'b0;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ft_clk) begin
    if (rst) begin
      state_q <= IDLE;
      wrn_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      wrn_q   <= wrn_d;
    end
  end

  assign ft_wrn      = wrn_q;
  assign tx_busy     = (state_q != IDLE);
  assign ft_data_oe  = (state_q == TURN) || (state_q == WRITE);
  assign ft_data_out = ft_data_oe ? fifo_head[FT_BYTE_W-1:0] : '0;

`ifdef FT_TX_SIWU_EN
  logic last_seen_q, last_seen_d;
  logic siwu_q, siwu_d;

  // Remember any message end popped during the burst; the flag is turned into
  // a single SIWU# pulse on the first IDLE cycle after RELEASE.
  always_comb begin
    last_seen_d = last_seen_q;
    siwu_d      = 1'b1;
    if (state_q == RELEASE) begin
      siwu_d      = !last_seen_q;
      last_seen_d = 1'b0;
    end else if (pop && fifo_head[FT_BYTE_W]) begin
      last_seen_d = 1'b1;
    end
  end

  always_ff @(posedge ft_clk) begin
    if (rst) begin
      last_seen_q <= 1'b0;
      siwu_q      <= 1'b1;
    end else begin
      last_seen_q <= last_seen_d;
      siwu_q      <= siwu_d;
    end
  end

  assign ft_siwu = siwu_q;
`else
  assign ft_siwu = 1'b1;
`endif

endmodule

// File: tb/tb_ft_tx.sv
// tb_ft_tx -- self-checking bench for ft_tx (DEPTH = 16).
// Model: a queue of bytes believed to be in the FIFO; the host side removes
// the front byte whenever WR# and TXE# are both low at a clock edge, and the
// byte seen on ft_data_out must equal it. Directed scenarios pin the model
// with literal byte orders, bus-phase sequences and occupancy values.
module tb_ft_tx;

  localparam int unsigned DEPTH = 16;

  logic       ft_clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;
  logic       rx_busy;
  logic       tx_busy;
  logic       ft_txen;
  logic       ft_wrn;
  logic [7:0] ft_data_out;
  logic       ft_data_oe;
  logic       ft_siwu;
  logic [4:0] level;

  ft_tx #(.DEPTH(DEPTH)) dut (
    .ft_clk      (ft_clk),
    .rst         (rst),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_last     (tx_last),
    .tx_ready    (tx_ready),
    .rx_busy     (rx_busy),
    .tx_busy     (tx_busy),
    .ft_txen     (ft_txen),
    .ft_wrn      (ft_wrn),
    .ft_data_out (ft_data_out),
    .ft_data_oe  (ft_data_oe),
    .ft_siwu     (ft_siwu),
    .level       (level)
  );

  initial forever #5 ft_clk = ~ft_clk;

  int         n_chk  = 0;
  int         n_fail = 0;
  bit         mon_en = 1'b0;
  logic [8:0] src_q[$];   // {last,data} waiting to be offered
  logic [8:0] mq[$];      // model FIFO contents
  logic [7:0] rxlog[$];   // bytes the host accepted
  logic [7:0] expb[$];
  int         phq[$];     // bus phase per busy cycle: 1 turn, 2 write, 3 release
  int         expq[$];
  int         prev_phase = 0;
  int         siwu_lows  = 0;
  int         siwu_good  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Source: offer the front of src_q until the DUT takes it.
  initial begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    tx_last  = 1'b0;
    forever begin
      @(negedge ft_clk);
      if (src_q.size() != 0) begin
        tx_valid = 1'b1;
        {tx_last, tx_data} = src_q[0];
      end else begin
        tx_valid = 1'b0;
        {tx_last, tx_data} = 9'h000;
      end
    end
  end

  // Compare process: outputs are stable over the cycle ending at this edge.
  always @(posedge ft_clk) begin
    logic [8:0] e;
    int ph;
    ph = !tx_busy ? 0 : (!ft_data_oe ? 3 : (ft_wrn ? 1 : 2));
    if (mon_en) begin
      check("level", level, mq.size());
      check("tx_ready", tx_ready, (mq.size() < DEPTH) && !rst);
      if (!ft_wrn) check("oe_during_write", ft_data_oe, 1);
      if (ft_data_oe) check("busy_during_oe", tx_busy, 1);
      if (ft_data_oe && mq.size() != 0) check("data_is_head", ft_data_out, mq[0][7:0]);
`ifndef FT_TX_SIWU_EN
      check("siwu_tied", ft_siwu, 1);
`endif
      if (!ft_siwu) begin
        siwu_lows++;
        if (prev_phase == 3 && !tx_busy) siwu_good++;
      end
    end
    if (ph != 0) phq.push_back(ph);
    prev_phase = ph;
    if (rst) begin
      mq.delete();
    end else begin
      if (!ft_wrn && !ft_txen) begin
        if (mq.size() == 0) begin
          check("write_with_empty_model", 1, 0);
        end else begin
          e = mq.pop_front();
          check("host_byte", ft_data_out, e[7:0]);
          rxlog.push_back(ft_data_out);
        end
      end
      if (tx_valid && tx_ready) begin
        mq.push_back({tx_last, tx_data});
        void'(src_q.pop_front());
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge ft_clk);
      #2;
    end
  endtask

  task automatic enqueue(input logic [7:0] b, input logic l);
    src_q.push_back({l, b});
  endtask

  task automatic wait_rx(input int n, input int budget);
    for (int i = 0; i < budget && rxlog.size() < n; i++) cyc(1);
    check("rx_count", rxlog.size(), n);
  endtask

  task automatic check_phases(input string name);
    check({name, "_len"}, phq.size(), expq.size());
    for (int i = 0; i < phq.size() && i < expq.size(); i++)
      check(name, phq[i], expq[i]);
  endtask

  task automatic check_rx(input string name);
    check({name, "_len"}, rxlog.size(), expb.size());
    for (int i = 0; i < rxlog.size() && i < expb.size(); i++)
      check(name, rxlog[i], expb[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    rx_busy = 1'b0;
    ft_txen = 1'b1;
    cyc(3);
    mon_en = 1'b1;

    // Reset state
    check("rst_tx_ready", tx_ready, 0);
    check("rst_level", level, 0);
    check("rst_wrn", ft_wrn, 1);
    check("rst_oe", ft_data_oe, 0);
    check("rst_data", ft_data_out, 0);
    check("rst_siwu", ft_siwu, 1);
    check("rst_busy", tx_busy, 0);
    rst = 1'b0;
    cyc(1);
    check("ready_after_rst", tx_ready, 1);

    // Three-byte burst: TURN, three back-to-back writes, RELEASE
    rxlog.delete(); phq.delete();
    ft_txen = 1'b0;
    enqueue(8'h11, 1'b0); enqueue(8'h22, 1'b0); enqueue(8'h33, 1'b0);
    wait_rx(3, 40);
    cyc(3);
    check("t1_busy", tx_busy, 0);
    check("t1_level", level, 0);
    check("t1_oe", ft_data_oe, 0);
    expb = '{8'h11, 8'h22, 8'h33}; check_rx("t1_bytes");
    expq = '{1, 2, 2, 2, 3};       check_phases("t1_phases");

    // TXE# rises on the edge of the second byte; resend from that byte
    ft_txen = 1'b1; rxlog.delete();
    enqueue(8'hA1, 1'b0); enqueue(8'hA2, 1'b0); enqueue(8'hA3, 1'b0); enqueue(8'hA4, 1'b0);
    cyc(8);
    check("t2_queued", level, 4);
    check("t2_wait_busy", tx_busy, 0);
    phq.delete();
    ft_txen = 1'b0;
    wait_rx(1, 20);
    ft_txen = 1'b1;
    cyc(4);
    check("t2_level_after_abort", level, 3);
    check("t2_busy_after_abort", tx_busy, 0);
    expq = '{1, 2, 2, 3}; check_phases("t2_abort_phases");
    expb = '{8'hA1};      check_rx("t2_first");
    phq.delete();
    ft_txen = 1'b0;
    wait_rx(4, 40);
    cyc(3);
    expq = '{1, 2, 2, 2, 3};                  check_phases("t2_resend_phases");
    expb = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};     check_rx("t2_bytes");

    // Fill: 17 offered, 16 stored, 17th held by source
    ft_txen = 1'b1; rxlog.delete();
    for (int i = 0; i < 17; i++) enqueue(8'h40 + 8'(i), 1'b0);
    cyc(24);
    check("t3_full_level", level, 16);
    check("t3_full_ready", tx_ready, 0);
    check("t3_held", src_q.size(), 1);
    check("t3_idle", tx_busy, 0);
    ft_txen = 1'b0;
    wait_rx(17, 80);
    cyc(3);
    check("t3_drained", level, 0);
    expb.delete();
    for (int i = 0; i < 17; i++) expb.push_back(8'h40 + 8'(i));
    check_rx("t3_bytes");

    // Reader owns the bus: wait; once released, TURN on the next cycle
    rx_busy = 1'b1; ft_txen = 1'b0; rxlog.delete();
    for (int i = 0; i < 5; i++) enqueue(8'h51 + 8'(i), 1'b0);
    cyc(10);
    check("t4_level", level, 5);
    check("t4_busy", tx_busy, 0);
    check("t4_oe", ft_data_oe, 0);
    phq.delete();
    rx_busy = 1'b0;
    cyc(1);
    check("t4_turn_busy", tx_busy, 1);
    check("t4_turn_oe", ft_data_oe, 1);
    check("t4_turn_wrn", ft_wrn, 1);
    rx_busy = 1'b1;
    wait_rx(5, 40);
    cyc(3);
    rx_busy = 1'b0;
    expq = '{1, 2, 2, 2, 2, 2, 3}; check_phases("t4_phases");
    expb = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h55}; check_rx("t4_bytes");

    // Reset in the middle of WRITE with eight bytes queued
    ft_txen = 1'b1; rxlog.delete();
    for (int i = 0; i < 8; i++) enqueue(8'h80 + 8'(i), 1'b0);
    cyc(12);
    ft_txen = 1'b0;
    for (int i = 0; i < 10 && ft_wrn; i++) cyc(1);
    check("t5_in_write", ft_wrn, 0);
    check("t5_level", level, 8);
    rst = 1'b1;
    cyc(1);
    check("t5_wrn", ft_wrn, 1);
    check("t5_oe", ft_data_oe, 0);
    check("t5_level_flushed", level, 0);
    check("t5_busy", tx_busy, 0);
    check("t5_ready_in_rst", tx_ready, 0);
    rst = 1'b0;
    cyc(3);
    check("t5_stays_idle", tx_busy, 0);
    check("t5_nothing_sent", rxlog.size(), 0);

    // Message-ending byte
    rxlog.delete(); siwu_lows = 0; siwu_good = 0;
    enqueue(8'hA5, 1'b1);
    wait_rx(1, 20);
    cyc(6);
    expb = '{8'hA5}; check_rx("t6_byte");
`ifdef FT_TX_SIWU_EN
    check("t6_siwu_pulses", siwu_lows, 1);
    check("t6_siwu_first_idle", siwu_good, 1);
    enqueue(8'h01, 1'b1); enqueue(8'h02, 1'b1);
    wait_rx(3, 30);
    cyc(6);
    check("t6_one_pulse_per_burst", siwu_lows, 2);
    check("t6_second_first_idle", siwu_good, 2);
`else
    check("t6_siwu_high", ft_siwu, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ft_tx.md
FT_TX -- requirements
Module: ft_tx

Interface
REQ-001 SHALL have parameter DEPTH, default 16, transmit FIFO depth in bytes (power of 2, >=4).
REQ-002 SHALL have port ft_clk  input  1  FT chip 60 MHz clock; sole clock.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port tx_data  input  8  byte from fabric.
REQ-005 SHALL have port tx_valid  input  1  tx_data valid.
REQ-006 SHALL have port tx_last  input  1  byte ends a host message.
REQ-007 SHALL have port tx_ready  output  1  FIFO accepts byte this cycle.
REQ-008 SHALL have port rx_busy  input  1  FT reader currently owns ft_data.
REQ-009 SHALL have port tx_busy  output  1  transmitter owns ft_data; reader holds off.
REQ-010 SHALL have port ft_txen  input  1  FT TXE#, active low, chip can accept data.
REQ-011 SHALL have port ft_wrn  output  1  FT WR#, active low.
REQ-012 SHALL have port ft_data_out  output  8  byte driven to ft_data.
REQ-013 SHALL have port ft_data_oe  output  1  top-level tristate enable for ft_data.
REQ-014 SHALL have port ft_siwu  output  1  FT SIWU#, active low send-immediate.
REQ-015 SHALL have port level  output  $clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-016 SHALL push {tx_last,tx_data} on a cycle with tx_valid && tx_ready; tx_ready = (level < DEPTH), combinational from registered count.
REQ-017 SHALL implement states IDLE, TURN, WRITE, RELEASE; tx_busy = (state != IDLE).
REQ-018 SHALL go IDLE->TURN when level>0 && !rx_busy && !ft_txen; otherwise stay IDLE.
REQ-019 SHALL, in TURN, hold ft_data_oe=1, ft_wrn=1, ft_data_out=FIFO head for one cycle, then enter WRITE.
REQ-020 SHALL, in WRITE, drive ft_wrn=0 only while the FIFO holds a head byte, ft_data_out = head byte; ft_wrn is a register.
REQ-021 SHALL count a byte transferred (pop) only on a rising edge where ft_wrn==0 && ft_txen==0; ft_data_out advances to next head the following cycle, zero-bubble for back-to-back bytes.
REQ-022 SHALL, when ft_wrn==0 && ft_txen==1 at an edge, not pop, drive ft_wrn=1 next cycle and enter RELEASE; byte retried later, never lost or duplicated.
REQ-023 SHALL, when the pop empties the FIFO, drive ft_wrn=1 next cycle and enter RELEASE.
REQ-024 SHALL, in RELEASE, hold ft_wrn=1, ft_data_oe=0 for one cycle, then enter IDLE.
REQ-025 SHALL ignore rx_busy outside IDLE.
REQ-026 SHALL permit push while popping; level changes by push-pop net.

Reset
REQ-027 SHALL, on rst, flush FIFO (level=0), state=IDLE, ft_wrn=1, ft_data_oe=0, ft_data_out=0, ft_siwu=1, tx_busy=0; tx_ready=0 while rst high.
REQ-028 SHALL, on rst mid-WRITE, release the bus on the next cycle; in-flight bytes discarded.

Configuration
REQ-029 SHALL, with FT_TX_SIWU_EN defined, pulse ft_siwu=0 for exactly one cycle on the first IDLE cycle after a popped byte had tx_last=1 (one pulse per RELEASE, even if several last bytes were popped).
REQ-030 SHALL, without FT_TX_SIWU_EN, tie ft_siwu=1 and not store tx_last (FIFO width 8).

Structure
REQ-031 SHALL take FT_BYTE_W=8 and enum ft_tx_state_t {IDLE,TURN,WRITE,RELEASE} from shared package ft_pkg.
REQ-032 SHALL instantiate sub-module ft_tx_fifo (synchronous FIFO, parameters WIDTH, DEPTH, level output).

Verification
REQ-033 SHALL cover: push 0x11,0x22,0x33 with ft_txen=0, rx_busy=0 -> TURN 1 cycle, ft_wrn low 3 consecutive cycles with 0x11,0x22,0x33, RELEASE, IDLE, level=0.
REQ-034 SHALL cover: 4 bytes queued, ft_txen high on edge of 2nd byte -> 2nd byte not popped, RELEASE; ft_txen low again -> resend from 2nd byte, host gets 4 bytes once each, in order.
REQ-035 SHALL cover: DEPTH=16, ft_txen=1, push 17 bytes -> tx_ready=0 after 16th, level=16, 17th held by source.
REQ-036 SHALL cover: rx_busy=1 with level=5 -> stays IDLE, ft_data_oe=0; rx_busy drops -> TURN next cycle.
REQ-037 SHALL cover: rst asserted during WRITE with level=8 -> next cycle ft_wrn=1, ft_data_oe=0, level=0, IDLE.
REQ-038 SHALL cover (FT_TX_SIWU_EN): 0xA5 with tx_last=1 -> single-cycle ft_siwu=0 on first IDLE cycle after RELEASE; without macro, ft_siwu constant 1.
